// File: rtl/iq_demod_pkg.sv
// rtl/iq_demod_pkg.sv - shared types and constants for the IQ demodulator front end
package iq_demod_pkg;

  localparam int DATA_W_DEFAULT = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } out_state_e;

endpackage

// File: rtl/adc_fifo.sv
// rtl/adc_fifo.sv - synchronous FIFO with push, pop, full and empty
// Extra pointer MSB separates full from empty; push is accepted when full if a pop happens too.
module adc_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/adc_iq_source.sv
// rtl/adc_iq_source.sv - ADC I/Q sampler with FIFO and valid/ready output; ADC_DROP_CNT_EN adds drop_cnt
// The shown sample stays at the FIFO head until it is accepted, so data is stable under backpressure.
module adc_iq_source
  import iq_demod_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int SAMPLE_DIV = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  input  logic [DATA_W-1:0] adc_i,
  input  logic [DATA_W-1:0] adc_q,
  output logic              valid_ADC,
  output logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_q,
  input  logic              ready_ADC,
  output logic              overflow
`ifdef ADC_DROP_CNT_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);

  localparam int CNT_W = $clog2(SAMPLE_DIV);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  logic [CNT_W-1:0]    div_cnt;
  logic                strobe;
  logic                xfer;
  logic                drop;
  logic                more_queued;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CW-1:0]       fifo_count;
  logic [2*DATA_W-1:0] fifo_head;
  out_state_e          state;
  out_state_e          state_nxt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      div_cnt <= '0;
    else if (!enable || strobe)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + CNT_W'(1);
  end

  assign strobe      = enable && (div_cnt == CNT_W'(SAMPLE_DIV - 1));
  assign valid_ADC   = (state != IDLE);
  assign xfer        = valid_ADC && ready_ADC;
  assign drop        = strobe && fifo_full && !xfer;
  // A sample pushed on the same edge counts as queued, so draining does not bubble.
  assign more_queued = (fifo_count > CW'(1)) || (strobe && !drop);

  adc_fifo #(
    .WIDTH (2 * DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (strobe),
    .wdata  ({adc_i, adc_q}),
    .pop    (xfer),
    .rdata  (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign data_i = valid_ADC ? fifo_head[2*DATA_W-1:DATA_W] : '0;
  assign data_q = valid_ADC ? fifo_head[DATA_W-1:0]        : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = SEND;
      SEND:    if (!ready_ADC)  state_nxt = WAIT;
               else             state_nxt = more_queued ? SEND : IDLE;
      WAIT:    if (ready_ADC)   state_nxt = more_queued ? SEND : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

`ifdef ADC_DROP_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      drop_cnt <= '0;
    else if (drop && (drop_cnt != 16'hFFFF))
      drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_adc_iq_source.sv
// tb/tb_adc_iq_source.sv - directed self-checking bench for adc_iq_source
module tb_adc_iq_source;

  logic        clk;
  logic        resetn;
  logic        enable;
  logic [11:0] adc_i;
  logic [11:0] adc_q;
  logic        valid_ADC;
  logic [11:0] data_i;
  logic [11:0] data_q;
  logic        ready_ADC;
  logic        overflow;
`ifdef ADC_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int cmp_cnt;
  int err_cnt;
  int cyc;

  adc_iq_source #(
    .DATA_W     (12),
    .SAMPLE_DIV (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .enable    (enable),
    .adc_i     (adc_i),
    .adc_q     (adc_q),
    .valid_ADC (valid_ADC),
    .data_i    (data_i),
    .data_q    (data_q),
    .ready_ADC (ready_ADC),
    .overflow  (overflow)
`ifdef ADC_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample n (1-based) is held on adc_i through the window that ends at edge 8*n.
  task automatic set_adc();
    adc_i = 12'(1 + cyc / 8);
    adc_q = 12'h800 + adc_i;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    set_adc();
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset(input logic en, input logic rdy);
    resetn    = 1'b0;
    enable    = 1'b0;
    ready_ADC = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn    = 1'b1;
    enable    = en;
    ready_ADC = rdy;
    cyc       = 0;
    set_adc();
  endtask

  task automatic check_out(input string name, input logic v, input logic [11:0] di);
    cmp_cnt++;
    if (valid_ADC !== v || (v && (data_i !== di || data_q !== 12'h800 + di))) begin
      err_cnt++;
      $display("FAIL %s cyc=%0d: valid=%b i=%0d q=%0h, expected valid=%b i=%0d q=%0h",
               name, cyc, valid_ADC, data_i, data_q, v, di, 12'h800 + di);
    end
  endtask

  task automatic check_ovf(input string name, input logic exp);
    cmp_cnt++;
    if (overflow !== exp) begin
      err_cnt++;
      $display("FAIL %s cyc=%0d: overflow=%b expected %b", name, cyc, overflow, exp);
    end
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    enable    = 1'b1;
    ready_ADC = 1'b0;
    adc_i     = 12'h123;
    adc_q     = 12'h456;
    repeat (4) @(posedge clk);
    #1;
    cmp_cnt++;
    if (valid_ADC !== 1'b0 || data_i !== 12'd0 || data_q !== 12'd0 || overflow !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset: valid=%b i=%0d q=%0d ovf=%b, expected all 0",
               valid_ADC, data_i, data_q, overflow);
    end
  endtask

  task automatic test_ramp();
    int exp_i;
    do_reset(1'b1, 1'b1);
    while (cyc < 27) begin
      step();
      exp_i = (cyc == 9 || cyc == 17 || cyc == 25) ? (cyc - 1) / 8 : 0;
      check_out("ramp", exp_i != 0, 12'(exp_i));
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b1, 1'b0);
    run_to(8);
    check_out("bp_pre", 1'b0, 12'd0);
    while (cyc < 28) begin
      step();
      check_out("bp_hold", 1'b1, 12'd1);
    end
    ready_ADC = 1'b1;
    step(); check_out("bp_drain2", 1'b1, 12'd2);
    step(); check_out("bp_drain3", 1'b1, 12'd3);
    step(); check_out("bp_idle", 1'b0, 12'd0);
  endtask

  task automatic test_overflow();
    do_reset(1'b1, 1'b0);
    run_to(39);
    check_ovf("ovf_before", 1'b0);
    step();
    check_ovf("ovf_set", 1'b1);
    run_to(48);
`ifdef ADC_DROP_CNT_EN
    cmp_cnt++;
    if (drop_cnt !== 16'd2) begin
      err_cnt++;
      $display("FAIL drop_cnt: got %0d expected 2", drop_cnt);
    end
`endif
    check_out("ovf_head", 1'b1, 12'd1);
    ready_ADC = 1'b1;
    enable    = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      step();
      check_out("ovf_order", 1'b1, 12'(k));
    end
    step();
    check_out("ovf_empty", 1'b0, 12'd0);
    check_ovf("ovf_sticky", 1'b1);
  endtask

  task automatic test_full_pop();
    do_reset(1'b1, 1'b0);
    run_to(39);
    ready_ADC = 1'b1;
    step();
    ready_ADC = 1'b0;
    check_ovf("fullpop_ovf", 1'b0);
    check_out("fullpop_next", 1'b1, 12'd2);
    step();
    enable    = 1'b0;
    ready_ADC = 1'b1;
    for (int k = 3; k <= 5; k++) begin
      step();
      check_out("fullpop_drain", 1'b1, 12'(k));
    end
    step();
    check_out("fullpop_idle", 1'b0, 12'd0);
    check_ovf("fullpop_ovf_end", 1'b0);
  endtask

  task automatic test_reset_wait();
    do_reset(1'b1, 1'b0);
    run_to(41);
    check_ovf("rw_pre_ovf", 1'b1);
    check_out("rw_pre", 1'b1, 12'd1);
    #2;
    resetn = 1'b0;
    #1;
    cmp_cnt++;
    if (valid_ADC !== 1'b0 || data_i !== 12'd0 || data_q !== 12'd0 || overflow !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_wait: valid=%b i=%0d q=%0d ovf=%b, expected all 0",
               valid_ADC, data_i, data_q, overflow);
    end
    enable    = 1'b0;
    ready_ADC = 1'b1;
    #1;
    resetn = 1'b1;
    repeat (12) begin
      step();
      check_out("rw_empty", 1'b0, 12'd0);
    end
  endtask

  task automatic test_enable_drop();
    do_reset(1'b1, 1'b0);
    run_to(16);
    enable = 1'b0;
    run_to(20);
    check_out("en_hold", 1'b1, 12'd1);
    ready_ADC = 1'b1;
    step();
    check_out("en_second", 1'b1, 12'd2);
    repeat (20) begin
      step();
      check_out("en_quiet", 1'b0, 12'd0);
    end
  endtask

  initial begin
    cmp_cnt   = 0;
    err_cnt   = 0;
    cyc       = 0;
    resetn    = 1'b0;
    enable    = 1'b0;
    ready_ADC = 1'b0;
    adc_i     = '0;
    adc_q     = '0;
    test_reset();
    test_ramp();
    test_backpressure();
    test_overflow();
    test_full_pop();
    test_reset_wait();
    test_enable_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
